// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, NOP word and width defaults.
package pipe_pkg;

  localparam int unsigned XlenDefault = 32;

  // ADDI x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic [1:0] StateRun      = 2'd0;
  localparam logic [1:0] StateRedirect = 2'd1;
  localparam logic [1:0] StateMemWait  = 2'd2;

  typedef enum logic [1:0] {
    StRun      = StateRun,
    StRedirect = StateRedirect,
    StMemWait  = StateMemWait
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/control bundle between the hazard/branch logic, the controller and the pipeline regs.
interface pipeline_ctrl_if #(
  parameter int unsigned XLEN = pipe_pkg::XlenDefault
);

  logic            hz_stall;
  logic            hz_flush;
  logic            ex_br_taken;
  logic [XLEN-1:0] ex_br_target;
  logic            mem_busy;

  logic            pc_we;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_id_we;
  logic            if_id_flush;
  logic            id_ex_we;
  logic            id_ex_flush;
  logic            ex_mem_we;
  logic            mem_wb_bubble;

  // Request side: hazard unit, EX branch resolution, MEM stage.
  modport master (
    output hz_stall, hz_flush, ex_br_taken, ex_br_target, mem_busy,
    input  pc_we, pc_redirect, redirect_pc, if_id_we, if_id_flush,
    input  id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble
  );

  // Controller side.
  modport slave (
    input  hz_stall, hz_flush, ex_br_taken, ex_br_target, mem_busy,
    output pc_we, pc_redirect, redirect_pc, if_id_we, if_id_flush,
    output id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: turns stall/branch/memory-busy requests into per-stage write enables,
// bubbles and PC redirect; tracks post-redirect squash and memory-wait freeze.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN        = XlenDefault,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic             run_rules;
  logic             br_inc;
  logic             stall_inc;
  logic             stall_req;
  logic [XLEN-1:0]  br_target;

  // Both hazard lines carry the same request; either one is honoured.
  assign stall_req = bus.hz_stall | bus.hz_flush;
  assign br_target = bus.ex_br_target;

  always_comb begin
    bus.pc_we         = 1'b1;
    bus.pc_redirect   = 1'b0;
    bus.redirect_pc   = '0;
    bus.if_id_we      = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_we      = 1'b1;
    bus.id_ex_flush   = 1'b0;
    bus.ex_mem_we     = 1'b1;
    bus.mem_wb_bubble = 1'b0;
    state_d           = state_q;
    redir_pend_d      = redir_pend_q;
    run_rules         = 1'b0;
    br_inc            = 1'b0;

    if (bus.mem_busy) begin
      bus.pc_we         = 1'b0;
      bus.if_id_we      = 1'b0;
      bus.id_ex_we      = 1'b0;
      bus.ex_mem_we     = 1'b0;
      bus.mem_wb_bubble = 1'b1;
      state_d           = StMemWait;
      // Remember the squash owed to the wrong-path fetch until memory releases.
      if (state_q == StRedirect) begin
        redir_pend_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRedirect: begin
          bus.if_id_flush = 1'b1;
          state_d         = StRun;
        end
        StMemWait: begin
          if (redir_pend_q) begin
            bus.if_id_flush = 1'b1;
            redir_pend_d    = 1'b0;
            state_d         = StRun;
          end else begin
            run_rules = 1'b1;
          end
        end
        default: run_rules = 1'b1;
      endcase

      if (run_rules) begin
        state_d = StRun;
        if (bus.ex_br_taken) begin
          // A coincident load-use stall belongs to a wrong-path instruction.
          bus.pc_redirect = 1'b1;
          bus.redirect_pc = br_target;
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          state_d         = StRedirect;
          br_inc          = 1'b1;
        end else if (stall_req) begin
          bus.pc_we       = 1'b0;
          bus.if_id_we    = 1'b0;
          bus.id_ex_flush = 1'b1;
        end
      end
    end

    if (rst) begin
      bus.pc_we         = 1'b0;
      bus.pc_redirect   = 1'b0;
      bus.redirect_pc   = '0;
      bus.if_id_we      = 1'b0;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_we      = 1'b0;
      bus.id_ex_flush   = 1'b1;
      bus.ex_mem_we     = 1'b0;
      bus.mem_wb_bubble = 1'b1;
      br_inc            = 1'b0;
    end
  end

  always_comb begin
    wait_d    = '0;
    mem_err_d = mem_err_q;
    if (bus.mem_busy) begin
      wait_d = (wait_q == WaitW'(MEM_TIMEOUT)) ? wait_q : wait_q + WaitW'(1);
      if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
        mem_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      redir_pend_q <= 1'b0;
      wait_q       <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      wait_q       <= wait_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_inc = !bus.pc_we && !rst;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed control vectors per scenario.
module tb_pipeline_ctrl;

  localparam int unsigned CntW = 4;

  // {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble}
  localparam logic [7:0] CtlRun    = 8'b1010_1010;
  localparam logic [7:0] CtlReset  = 8'b0001_0101;
  localparam logic [7:0] CtlStall  = 8'b0000_1110;
  localparam logic [7:0] CtlBranch = 8'b1111_1110;
  localparam logic [7:0] CtlRedir  = 8'b1011_1010;
  localparam logic [7:0] CtlFreeze = 8'b0000_0001;

  logic            clk;
  logic            rst;
  logic            mem_err;
  logic [CntW-1:0] stall_cycles;
  logic [CntW-1:0] redirect_count;
  logic [7:0]      ctl;

  int vectors = 0;
  int errors  = 0;

  pipeline_ctrl_if #(.XLEN(32)) bus ();

  pipeline_ctrl #(
    .XLEN        (32),
    .CNT_W       (CntW),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
  );

  assign ctl = {bus.pc_we, bus.pc_redirect, bus.if_id_we, bus.if_id_flush,
                bus.id_ex_we, bus.id_ex_flush, bus.ex_mem_we, bus.mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.hz_stall     = 1'b0;
    bus.hz_flush     = 1'b0;
    bus.ex_br_taken  = 1'b0;
    bus.ex_br_target = 32'h0;
    bus.mem_busy     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.mem_busy = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    #2;
    vectors++;
    if (ctl !== CtlReset) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, CtlReset);
    end
    vectors++;
    if (bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_redirect_pc: got %h expected 0", bus.redirect_pc);
    end
    vectors++;
    if ({stall_cycles, redirect_count, mem_err} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%b expected 0/0/0",
               stall_cycles, redirect_count, mem_err);
    end
    bus.mem_busy = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (ctl !== CtlRun) begin
      errors++;
      $display("FAIL reset_release_ctl: got %b expected %b", ctl, CtlRun);
    end
    next_cycle();
    vectors++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_stall: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    bus.hz_stall = 1'b1;
    bus.hz_flush = 1'b1;
    #2;
    vectors++;
    if (ctl !== CtlStall) begin
      errors++;
      $display("FAIL load_use_ctl: got %b expected %b", ctl, CtlStall);
    end
    next_cycle();
    clear_inputs();
    #2;
    vectors++;
    if (ctl !== CtlRun) begin
      errors++;
      $display("FAIL load_use_after_ctl: got %b expected %b", ctl, CtlRun);
    end
    vectors++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_0100;
    bus.hz_stall     = 1'b1;
    bus.hz_flush     = 1'b1;
    #2;
    vectors++;
    if (ctl !== CtlBranch) begin
      errors++;
      $display("FAIL branch_ctl: got %b expected %b", ctl, CtlBranch);
    end
    vectors++;
    if (bus.redirect_pc !== 32'h0000_0100) begin
      errors++;
      $display("FAIL branch_target: got %h expected 00000100", bus.redirect_pc);
    end
    next_cycle();
    // Requests in the squash cycle must be ignored.
    bus.ex_br_target = 32'h0000_0dea;
    #2;
    vectors++;
    if (ctl !== CtlRedir) begin
      errors++;
      $display("FAIL branch_squash_ctl: got %b expected %b", ctl, CtlRedir);
    end
    vectors++;
    if (redirect_count !== 4'd1 || stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL branch_counts: got redir=%0d stall=%0d expected 1/0",
               redirect_count, stall_cycles);
    end
    next_cycle();
    clear_inputs();
    #2;
    vectors++;
    if (ctl !== CtlRun || redirect_count !== 4'd1) begin
      errors++;
      $display("FAIL branch_after: got %b redir=%0d expected %b redir=1",
               ctl, redirect_count, CtlRun);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    bus.mem_busy    = 1'b1;
    bus.ex_br_taken = 1'b1;
    bus.hz_stall    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      vectors++;
      if (ctl !== CtlFreeze) begin
        errors++;
        $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, ctl, CtlFreeze);
      end
      next_cycle();
    end
    clear_inputs();
    #2;
    vectors++;
    if (ctl !== CtlRun) begin
      errors++;
      $display("FAIL mem_wait_release: got %b expected %b", ctl, CtlRun);
    end
    vectors++;
    if (stall_cycles !== 4'd4 || redirect_count !== 4'd0) begin
      errors++;
      $display("FAIL mem_wait_counts: got stall=%0d redir=%0d expected 4/0",
               stall_cycles, redirect_count);
    end
  endtask

  task automatic test_busy_redirect();
    apply_reset();
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_0200;
    #2;
    vectors++;
    if (ctl !== CtlBranch) begin
      errors++;
      $display("FAIL busy_redir_t0: got %b expected %b", ctl, CtlBranch);
    end
    next_cycle();
    clear_inputs();
    bus.mem_busy = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #2;
      vectors++;
      if (ctl !== CtlFreeze) begin
        errors++;
        $display("FAIL busy_redir_t%0d: got %b expected %b", i, ctl, CtlFreeze);
      end
      next_cycle();
    end
    bus.mem_busy = 1'b0;
    #2;
    vectors++;
    if (ctl !== CtlRedir) begin
      errors++;
      $display("FAIL busy_redir_t3: got %b expected %b", ctl, CtlRedir);
    end
    next_cycle();
    #2;
    vectors++;
    if (ctl !== CtlRun) begin
      errors++;
      $display("FAIL busy_redir_t4: got %b expected %b", ctl, CtlRun);
    end
    vectors++;
    if (stall_cycles !== 4'd2 || redirect_count !== 4'd1) begin
      errors++;
      $display("FAIL busy_redir_counts: got stall=%0d redir=%0d expected 2/1",
               stall_cycles, redirect_count);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      vectors++;
      if (mem_err !== (i >= 4)) begin
        errors++;
        $display("FAIL timeout_err[%0d]: got %b expected %b", i, mem_err, (i >= 4));
      end
      next_cycle();
    end
    bus.mem_busy = 1'b0;
    next_cycle();
    #2;
    vectors++;
    if (mem_err !== 1'b1 || ctl !== CtlRun) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b ctl=%b expected 1/%b", mem_err, ctl, CtlRun);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #2;
    vectors++;
    if (mem_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", mem_err);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) next_cycle();
    bus.mem_busy = 1'b0;
    #2;
    vectors++;
    if (stall_cycles !== 4'hf) begin
      errors++;
      $display("FAIL stall_saturate: got %0d expected 15", stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.hz_stall = 1'b1;
    bus.hz_flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      vectors++;
      if (ctl !== CtlStall) begin
        errors++;
        $display("FAIL b2b_stall[%0d]: got %b expected %b", i, ctl, CtlStall);
      end
      next_cycle();
    end
    clear_inputs();
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_0400;
    #2;
    vectors++;
    if (ctl !== CtlBranch || bus.redirect_pc !== 32'h0000_0400) begin
      errors++;
      $display("FAIL b2b_branch: got %b pc=%h expected %b pc=00000400",
               ctl, bus.redirect_pc, CtlBranch);
    end
    next_cycle();
    clear_inputs();
    #2;
    vectors++;
    if (stall_cycles !== 4'd2 || redirect_count !== 4'd1) begin
      errors++;
      $display("FAIL b2b_counts: got stall=%0d redir=%0d expected 2/1",
               stall_cycles, redirect_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_busy_redirect();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
